// File: rtl/calc_method_select.sv
`default_nettype none
// calc_method_select: synchronised, debounced push-button method selector with confirm lock.
// Rev 1.0
module calc_method_select #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int NUM_METHODS     = 5,
  parameter int SYNC_STAGES     = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_next,
  input  logic       btn_prev,
  input  logic       btn_confirm,
  input  logic       calc_done,
  output logic [2:0] method_sel,
  output logic       method_valid,
  output logic       locked
);

  localparam int               CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [2:0]       SEL_LAST = 3'(NUM_METHODS - 1);
  localparam int               B_NEXT   = 0;
  localparam int               B_PREV   = 1;
  localparam int               B_CONF   = 2;

  typedef enum logic [0:0] {
    SELECT = 1'b0,
    LOCKED = 1'b1
  } state_t;

  logic [2:0] raw;
  logic [2:0] press;

  assign raw = {btn_confirm, btn_prev, btn_next};

  for (genvar b = 0; b < 3; b++) begin : g_btn
    logic [SYNC_STAGES-1:0] sync;
    logic [CNT_W-1:0]       cnt;
    logic                   stable;
    logic                   stable_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync     <= '0;
        cnt      <= '0;
        stable   <= 1'b0;
        stable_q <= 1'b0;
      end else begin
        sync     <= {sync[SYNC_STAGES-2:0], raw[b]};
        stable_q <= stable;
        // A level change is accepted only after DEBOUNCE_CYCLES consecutive disagreeing samples.
        if (sync[SYNC_STAGES-1] == stable) begin
          cnt <= '0;
        end else if (cnt == CNT_LAST) begin
          stable <= ~stable;
          cnt    <= '0;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end

    assign press[b] = stable & ~stable_q;
  end

  state_t     state;
  state_t     state_nx;
  logic [2:0] sel_nx;
  logic       valid_nx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= SELECT;
      method_sel   <= 3'd0;
      method_valid <= 1'b0;
      locked       <= 1'b0;
    end else begin
      state        <= state_nx;
      method_sel   <= sel_nx;
      method_valid <= valid_nx;
      locked       <= (state_nx == LOCKED);
    end
  end

  always_comb begin
    state_nx = state;
    sel_nx   = method_sel;
    valid_nx = 1'b0;
    case (state)
      SELECT: begin
        // Confirm takes priority over any simultaneous stepping.
        if (press[B_CONF]) begin
          valid_nx = 1'b1;
          state_nx = LOCKED;
        end else if (press[B_NEXT] && !press[B_PREV]) begin
          sel_nx = (method_sel == SEL_LAST) ? 3'd0 : method_sel + 3'd1;
        end else if (press[B_PREV] && !press[B_NEXT]) begin
          sel_nx = (method_sel == 3'd0) ? SEL_LAST : method_sel - 3'd1;
        end
      end
      LOCKED: begin
        if (calc_done) begin
          state_nx = SELECT;
        end
      end
      default: begin
        state_nx = SELECT;
      end
    endcase
  end

endmodule
`default_nettype wire
